// File: rtl/bubble_page_reader_pkg.sv
// rtl/bubble_page_reader_pkg.sv - shared FSM state codes and CRC constants for the bubble page reader
package bubble_page_reader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_REPL  = 3'd2;
   localparam state_t ST_LAT   = 3'd3;
   localparam state_t ST_SHIFT = 3'd4;
   localparam state_t ST_FIN   = 3'd5;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/bubble_crc16.sv
// rtl/bubble_crc16.sv - byte-wide CRC-16-CCITT update, MSB first
module bubble_crc16
   import bubble_page_reader_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[15] ? ({crc_out[14:0], 1'b0} ^ CRC_POLY) : {crc_out[14:0], 1'b0};
      end
   end

endmodule

// File: rtl/bubble_page_reader.sv
// rtl/bubble_page_reader.sv - bubble memory page reader: shift/replicate sequencing, dual-lane bit capture, byte handshake
// Define BUBBLE_READER_CRC_EN to check the trailing page CRC-16 and report CRC_ERR.
module bubble_page_reader
   import bubble_page_reader_pkg::*;
#(
   parameter int BIT_DIV    = 240,
   parameter int SETUP_CYC  = 96,
   parameter int REP_CYC    = 48,
   parameter int LAT_BITS   = 16,
   parameter int PAGE_BYTES = 64
)(
   input  logic       MCLK,
   input  logic       RST,
   input  logic       START,
   input  logic       DOUT0,
   input  logic       DOUT1,
   output logic       nBSEN,
   output logic       nREPEN,
   output logic [7:0] DATA,
   output logic       VALID,
   input  logic       READY,
   output logic       BUSY,
   output logic       DONE,
   output logic       OVERRUN,
   output logic       CRC_ERR
);

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic [9:0]  bitcnt;
   logic [1:0]  paircnt;
   logic [8:0]  bytecnt;
   logic [7:0]  sr;
   logic [1:0]  sync0, sync1;

   logic       start_acc, period_end, sample, byte_done, last_byte;
   logic [7:0] byte_nxt;

   assign start_acc  = (state == ST_IDLE) && START;
   assign period_end = (bitcnt == 10'(BIT_DIV - 1));
   assign sample     = (state == ST_SHIFT) && (bitcnt == 10'(BIT_DIV / 2));
   assign byte_nxt   = {sync1[1], sync0[1], sr[7:2]};
   assign byte_done  = sample && (paircnt == 2'd3);
   assign last_byte  = byte_done && (bytecnt == 9'(PAGE_BYTES - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (START) state_nxt = ST_SETUP;
         ST_SETUP: if (cnt == 16'(SETUP_CYC - 1)) state_nxt = ST_REPL;
         ST_REPL:  if (cnt == 16'(REP_CYC - 1)) state_nxt = ST_LAT;
         ST_LAT:   if (period_end && cnt == 16'(LAT_BITS - 1)) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_byte) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state register.
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         nBSEN  <= 1'b1;
         nREPEN <= 1'b1;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         state  <= state_nxt;
         nBSEN  <= (state_nxt == ST_IDLE) || (state_nxt == ST_FIN);
         nREPEN <= (state_nxt != ST_REPL);
         BUSY   <= (state_nxt != ST_IDLE);
         DONE   <= (state_nxt == ST_FIN);
      end
   end

   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         bitcnt  <= '0;
         paircnt <= '0;
         bytecnt <= '0;
         sr      <= '0;
         sync0   <= '0;
         sync1   <= '0;
      end else begin
         sync0 <= {sync0[0], DOUT0};
         sync1 <= {sync1[0], DOUT1};

         if (state_nxt != state)
            cnt <= '0;
         else if (state == ST_SETUP || state == ST_REPL || (state == ST_LAT && period_end))
            cnt <= cnt + 16'd1;

         // Bit timing restarts on LAT entry and again on SHIFT entry.
         if (state_nxt != state)
            bitcnt <= '0;
         else if (state == ST_LAT || state == ST_SHIFT)
            bitcnt <= period_end ? 10'd0 : bitcnt + 10'd1;

         if (state_nxt != ST_SHIFT)
            paircnt <= '0;
         else if (sample)
            paircnt <= paircnt + 2'd1;

         if (state_nxt != ST_SHIFT)
            bytecnt <= '0;
         else if (byte_done)
            bytecnt <= bytecnt + 9'd1;

         if (sample)
            sr <= byte_nxt;
      end
   end

   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         DATA    <= '0;
         VALID   <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         if (byte_done) begin
            if (!VALID || READY) begin
               DATA  <= byte_nxt;
               VALID <= 1'b1;
            end
         end else if (VALID && READY) begin
            VALID <= 1'b0;
         end

         if (start_acc)
            OVERRUN <= 1'b0;
         else if (byte_done && VALID && !READY)
            OVERRUN <= 1'b1;
      end
   end

`ifdef BUBBLE_READER_CRC_EN
   logic [15:0] crc, crc_upd;
   logic [7:0]  crc_hi;

   bubble_crc16 u_crc (
      .crc_in  (crc),
      .data    (byte_nxt),
      .crc_out (crc_upd)
   );

   // The last two page bytes carry the expected CRC, high byte first.
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         crc     <= CRC_INIT;
         crc_hi  <= '0;
         CRC_ERR <= 1'b0;
      end else if (start_acc) begin
         crc     <= CRC_INIT;
         CRC_ERR <= 1'b0;
      end else if (byte_done) begin
         if (bytecnt < 9'(PAGE_BYTES - 2))
            crc <= crc_upd;
         else if (bytecnt == 9'(PAGE_BYTES - 2))
            crc_hi <= byte_nxt;
         if (last_byte)
            CRC_ERR <= (crc != {crc_hi, byte_nxt});
      end
   end
`else
   assign CRC_ERR = 1'b0;
`endif

endmodule
